// File: rtl/syncgen.sv
// syncgen: sync/veto pattern generator for the downstream clock state machine.
// Sequence: LEAD pulse, then N phase pairs (LOW, HOLD x stretch, TURN), then IDLE.
// Optional macro SYNCGEN_MODEL_EN compiles in a shadow of the downstream
// clock state machine driving sync_ref/phase_ref; otherwise those are tied to 0.
module syncgen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] count,
    input  logic [3:0]       stretch,
    output logic             syncout,
    output logic             vetoout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pairs,
    output logic             sync_ref,
    output logic             phase_ref
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_LOW,
        S_HOLD,
        S_TURN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_stretch;
    logic [3:0]       r_hcnt;
    logic             r_done;
    logic [CNT_W-1:0] r_pairs;

    logic [CNT_W:0]   w_pairs_nx;
    logic             w_cont;

    // Compare one bit wider so pairs+1 cannot wrap against a large count.
    assign w_pairs_nx = {1'b0, r_pairs} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cont     = !stop && ((r_count == '0) || (w_pairs_nx < {1'b0, r_count}));

    // Sequencer state, latched parameters, hold counter, pair counter and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_stretch <= '0;
            r_hcnt    <= '0;
            r_done    <= 1'b0;
            r_pairs   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count   <= count;
                        r_stretch <= stretch;
                        r_pairs   <= '0;
                        r_state   <= S_LEAD;
                    end
                end
                S_LEAD: r_state <= S_LOW;
                S_LOW: begin
                    if (r_stretch != '0) begin
                        r_hcnt  <= r_stretch;
                        r_state <= S_HOLD;
                    end else begin
                        r_state <= S_TURN;
                    end
                end
                S_HOLD: begin
                    if (r_hcnt == 4'd1) begin
                        r_state <= S_TURN;
                    end else begin
                        r_hcnt <= r_hcnt - 4'd1;
                    end
                end
                S_TURN: begin
                    r_pairs <= w_pairs_nx[CNT_W-1:0];
                    if (w_cont) begin
                        r_state <= S_LOW;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output decode from the state register; TURN drives sync only when continuing.
    always_comb begin
        syncout = 1'b0;
        vetoout = 1'b0;
        busy    = (r_state != S_IDLE);
        case (r_state)
            S_LEAD:  syncout = 1'b1;
            S_HOLD:  vetoout = 1'b1;
            S_TURN:  syncout = w_cont;
            default: ;
        endcase
    end

    assign done  = r_done;
    assign pairs = r_pairs;

`ifdef SYNCGEN_MODEL_EN
    typedef enum logic [1:0] {
        P0,
        P1,
        P2,
        P3
    } mstate_t;

    mstate_t r_mst;

    // Shadow of the downstream clock state machine, fed by syncout/vetoout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mst <= P0;
        end else begin
            case (r_mst)
                P0: if (syncout) r_mst <= P1;
                P1: r_mst <= syncout ? P2 : P3;
                P2: if (!syncout) r_mst <= P3;
                P3: if (!vetoout) r_mst <= syncout ? P1 : P0;
                default: r_mst <= P0;
            endcase
        end
    end

    assign sync_ref  = (r_mst == P1);
    assign phase_ref = (r_mst == P2) || (r_mst == P3);
`else
    assign sync_ref  = 1'b0;
    assign phase_ref = 1'b0;
`endif

endmodule

// File: tb/tb_syncgen.sv
// tb_syncgen: directed test of syncgen with cycle-by-cycle expected outputs.
module tb_syncgen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] count;
    logic [3:0]  stretch;
    logic        syncout;
    logic        vetoout;
    logic        busy;
    logic        done;
    logic [15:0] pairs;
    logic        sync_ref;
    logic        phase_ref;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    syncgen #(.CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .count     (count),
        .stretch   (stretch),
        .syncout   (syncout),
        .vetoout   (vetoout),
        .busy      (busy),
        .done      (done),
        .pairs     (pairs),
        .sync_ref  (sync_ref),
        .phase_ref (phase_ref)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic es, input logic ev, input logic eb,
                           input logic ed, input int ep, input logic ems, input logic emp);
`ifndef SYNCGEN_MODEL_EN
        ems = 1'b0;
        emp = 1'b0;
`endif
        chk({tag, ".syncout"},   {31'd0, syncout},   {31'd0, es});
        chk({tag, ".vetoout"},   {31'd0, vetoout},   {31'd0, ev});
        chk({tag, ".busy"},      {31'd0, busy},      {31'd0, eb});
        chk({tag, ".done"},      {31'd0, done},      {31'd0, ed});
        chk({tag, ".pairs"},     {16'd0, pairs},     ep);
        chk({tag, ".sync_ref"},  {31'd0, sync_ref},  {31'd0, ems});
        chk({tag, ".phase_ref"}, {31'd0, phase_ref}, {31'd0, emp});
    endtask

    // Caller has start=1 with count/stretch set while the DUT is idle (or in its done cycle).
    task automatic run_seq(input int n, input int s, input int stop_pair,
                           input bit pulse_busy, input bit b2b);
        int total;
        logic es;
        total = (n == 0) ? stop_pair : n;
        tick;
        start   = 1'b0;
        stop    = 1'b0;
        count   = 16'h0001;
        stretch = 4'hF;
        chk_all("lead", 1, 0, 1, 0, 0, 0, 0);
        for (int p = 1; p <= total; p++) begin
            tick;
            chk_all("low", 0, 0, 1, 0, p - 1, 1, 0);
            if (pulse_busy && p == 1) start = 1'b1;
            for (int h = 0; h < s; h++) begin
                tick;
                start = 1'b0;
                chk_all("hold", 0, 1, 1, 0, p - 1, 0, 1);
                if (p == stop_pair && h == 0) stop = 1'b1;
            end
            tick;
            start = 1'b0;
            es = (p != stop_pair) && (n == 0 || p < n);
            chk_all("turn", es, 0, 1, 0, p - 1, 0, 1);
            if (b2b && p == total) begin
                start   = 1'b1;
                count   = 16'(n);
                stretch = 4'(s);
            end
        end
        tick;
        chk_all("done", 0, 0, 0, 1, total, 0, 0);
        stop = 1'b0;
        if (!b2b) begin
            tick;
            chk_all("idle", 0, 0, 0, 0, total, 0, 0);
        end
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        count   = '0;
        stretch = '0;
        #1 reset = 1'b1;
        #1 chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of HOLD aborts without a done pulse.
        count   = 16'd3;
        stretch = 4'd2;
        start   = 1'b1;
        tick;
        start = 1'b0;
        chk_all("a_lead", 1, 0, 1, 0, 0, 0, 0);
        tick;
        chk_all("a_low", 0, 0, 1, 0, 0, 1, 0);
        tick;
        chk_all("a_hold", 0, 1, 1, 0, 0, 0, 1);
        #2 reset = 1'b1;
        #1 chk_all("a_async_rst", 0, 0, 0, 0, 0, 0, 0);
        tick;
        reset = 1'b0;
        tick;
        chk_all("a_idle1", 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk_all("a_idle2", 0, 0, 0, 0, 0, 0, 0);

        // Single pair, no stretch.
        count   = 16'd1;
        stretch = 4'd0;
        start   = 1'b1;
        run_seq(1, 0, 0, 0, 0);

        // Three pairs with two veto cycles each.
        count   = 16'd3;
        stretch = 4'd2;
        start   = 1'b1;
        run_seq(3, 2, 0, 0, 0);

        // stop alone in IDLE is ignored.
        stop = 1'b1;
        tick;
        chk_all("stop_idle1", 0, 0, 0, 0, 3, 0, 0);
        tick;
        chk_all("stop_idle2", 0, 0, 0, 0, 3, 0, 0);

        // start wins over stop; free-running, stopped during HOLD of pair 5.
        count   = 16'd0;
        stretch = 4'd1;
        start   = 1'b1;
        run_seq(0, 1, 5, 0, 0);

        // Back-to-back with a start pulse while busy.
        count   = 16'd2;
        stretch = 4'd0;
        start   = 1'b1;
        run_seq(2, 0, 0, 1, 1);
        run_seq(2, 0, 0, 0, 0);

        // Four pairs with three veto cycles each.
        count   = 16'd4;
        stretch = 4'd3;
        start   = 1'b1;
        run_seq(4, 3, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
